branch_hazard_unit: RTL and testbench
=====================================

BRANCH_HAZARD_UNIT -- requirements
Module: branch_hazard_unit

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the statistics counters (used only when BRANCH_HAZARD_STATS_EN is defined).
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port branch, input, 1, EX-stage instruction is a conditional branch.
REQ-005 SHALL have port zero, input, 1, ALU zero flag of the EX-stage compare.
REQ-006 SHALL have port flush_ifid, output, 1, squash the IF/ID register at the next edge.
REQ-007 SHALL have port flush_idex, output, 1, squash the ID/EX register at the next edge.
REQ-008 SHALL have port pc_src, output, 1, 1 selects the branch target, 0 selects PC+4.
REQ-009 SHALL, with BRANCH_HAZARD_STATS_EN only, have port branch_count, output, CNT_W, branches resolved since reset.
REQ-010 SHALL, with BRANCH_HAZARD_STATS_EN only, have port taken_count, output, CNT_W, taken branches since reset.

Function
REQ-011 SHALL define taken = branch & zero & ~taken_q, where taken_q is a 1-bit register set to the registered value of taken.
REQ-012 SHALL drive pc_src, flush_ifid and flush_idex combinationally equal to taken, with zero-cycle latency in the same cycle as the inputs.
REQ-013 SHALL drive all three outputs 0 for (branch,zero) = 00, 01 and 10.
REQ-014 SHALL drive all three outputs 1 for (branch,zero) = 11 when taken_q = 0.
REQ-015 SHALL, in the cycle immediately after a taken branch, mask branch, because the EX slot then holds a flushed bubble; all outputs SHALL be 0 that cycle regardless of the inputs.
REQ-016 SHALL, for branch=1 held with zero=1 for consecutive cycles, produce a taken-pulse pattern of 1,0,1,0,... cycle by cycle.
REQ-017 SHALL ignore zero whenever branch=0; zero alone never flushes or redirects.
REQ-018 SHALL, with stats enabled, increment branch_count on each edge where branch & ~taken_q is 1.
REQ-019 SHALL, with stats enabled, increment taken_count on each edge where taken is 1.
REQ-020 SHALL wrap both counters modulo 2^CNT_W, with no saturation.

Reset
REQ-021 SHALL asynchronously clear taken_q and both counters while rst=1, independent of clk.
REQ-022 SHALL force pc_src, flush_ifid and flush_idex to 0 while rst=1.
REQ-023 SHALL evaluate the first taken branch after rst deasserts normally, with no masking.
REQ-024 SHALL, when rst asserts in the same cycle as a taken branch, clear the outputs immediately and leave taken_q at 0 after release.

Configuration
REQ-025 SHALL, when macro BRANCH_HAZARD_STATS_EN is defined, include the branch_count and taken_count ports and counter logic.
REQ-026 SHALL, when BRANCH_HAZARD_STATS_EN is undefined, omit both ports and counters entirely, leaving all other behaviour identical.

Structure
REQ-027 SHALL take CNT_W default and PC-source encodings (PCSRC_SEQ=0, PCSRC_BR=1) from the shared pipeline package.
REQ-028 SHALL place the two statistics counters in one reusable sub-module, branch_stat_counter, instantiated twice.

Verification
REQ-029 SHALL cover reset: rst=1 with branch=1, zero=1 -> all outputs 0 and counters 0; release -> outputs 1 in the same cycle.
REQ-030 SHALL cover the truth table: branch/zero sequence 00, 10, 01, 11 one cycle each after reset -> outputs 0, 0, 0, 1.
REQ-031 SHALL cover back-to-back branches: branch=1, zero=1 held 4 cycles -> pc_src pattern 1, 0, 1, 0; with stats, taken_count=2 and branch_count=2.
REQ-032 SHALL cover the not-taken path: branch=1, zero=0 for 3 cycles -> outputs 0; with stats, branch_count=3 and taken_count=0.
REQ-033 SHALL cover mid-operation reset: rst pulsed asynchronously between edges during a taken cycle -> outputs drop to 0 immediately and no masking after release.
REQ-034 SHALL cover counter wrap: CNT_W=2, 5 taken branches separated by idle cycles -> taken_count=1.

Source files
------------

// File: rtl/branch_hazard_unit_pkg.sv
// Purpose : shared pipeline definitions for the branch hazard unit (PC-source
//           encodings, default statistics counter width, control bundle type).
// Latency : n/a (definitions only).
// Backpressure : n/a.
package branch_hazard_unit_pkg;

    // Default width of the optional statistics counters.
    localparam int CNT_W_DEFAULT = 32;

    // PC multiplexer select encodings.
    localparam logic PCSRC_SEQ = 1'b0;  // PC + 4
    localparam logic PCSRC_BR  = 1'b1;  // branch target

    // Control bundle produced by the hazard unit each cycle.
    typedef struct packed {
        logic pc_src;
        logic flush_ifid;
        logic flush_idex;
    } hazard_ctl_t;

    // A taken branch redirects fetch and squashes both younger stages.
    function automatic hazard_ctl_t hazard_ctl(input logic taken);
        hazard_ctl_t ctl;
        ctl.pc_src     = taken ? PCSRC_BR : PCSRC_SEQ;
        ctl.flush_ifid = taken;
        ctl.flush_idex = taken;
        return ctl;
    endfunction

endpackage

// File: rtl/branch_stat_counter.sv
// Purpose : free-running event counter, wraps modulo 2^W (no saturation).
// Latency : count reflects an inc pulse one clock edge after it is sampled.
// Backpressure : none; inc is sampled unconditionally every rising edge.
//
// Ports: clk, rst (async active-high clear), inc (count enable), count[W-1:0].
module branch_stat_counter
    import branch_hazard_unit_pkg::*;
#(
    parameter int W = CNT_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/branch_hazard_unit.sv
// Purpose : resolves EX-stage conditional branches; redirects the PC and
//           squashes IF/ID and ID/EX on a taken branch.
// Latency : zero cycles, outputs are combinational from branch/zero/taken_q.
// Backpressure : none; one branch decision per cycle, no stall input.
//
// Ports: clk, rst (async active-high), branch, zero -> pc_src, flush_ifid,
//        flush_idex. When BRANCH_HAZARD_STATS_EN is defined the unit also
//        exports branch_count and taken_count (CNT_W bits, wrapping).
module branch_hazard_unit
    import branch_hazard_unit_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             branch,
    input  logic             zero,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             pc_src
`ifdef BRANCH_HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] taken_count
`endif
);

    if (CNT_W < 1) begin : g_cnt_w_chk
        $error("branch_hazard_unit: CNT_W must be at least 1");
    end

    logic        taken;
    logic        taken_q;
    logic        taken_q_d;
    hazard_ctl_t ctl;

    // The cycle after a taken branch the EX slot holds the bubble created by
    // the flush, so whatever branch says there is stale and must be ignored.
    // rst gates taken directly so the outputs drop in the same delta as the
    // reset edge rather than waiting for taken_q to clear.
    always_comb begin
        taken     = ~rst & branch & zero & ~taken_q;
        taken_q_d = taken;
        ctl       = hazard_ctl(taken);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            taken_q <= 1'b0;
        end else begin
            taken_q <= taken_q_d;
        end
    end

    assign pc_src     = ctl.pc_src;
    assign flush_ifid = ctl.flush_ifid;
    assign flush_idex = ctl.flush_idex;

`ifdef BRANCH_HAZARD_STATS_EN
    // A branch counts as resolved only when it is a real instruction, i.e.
    // not the masked bubble following a taken branch.
    logic resolved;

    always_comb begin
        resolved = ~rst & branch & ~taken_q;
    end

    branch_stat_counter #(
        .W (CNT_W)
    ) u_branch_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (resolved),
        .count (branch_count)
    );

    branch_stat_counter #(
        .W (CNT_W)
    ) u_taken_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (taken),
        .count (taken_count)
    );
`endif

endmodule

// File: tb/tb_branch_hazard_unit.sv
// Directed bench for branch_hazard_unit. Inputs change 1 time unit after a
// rising edge; outputs are sampled mid-cycle, well away from either edge.
// Counter checks apply only when BRANCH_HAZARD_STATS_EN is defined.
module tb_branch_hazard_unit;

    localparam int TB_CNT_W = 2;

    logic clk;
    logic rst;
    logic branch;
    logic zero;
    logic flush_ifid;
    logic flush_idex;
    logic pc_src;
`ifdef BRANCH_HAZARD_STATS_EN
    logic [TB_CNT_W-1:0] branch_count;
    logic [TB_CNT_W-1:0] taken_count;
`endif

    int n_cmp;
    int n_bad;

    branch_hazard_unit #(
        .CNT_W (TB_CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .branch       (branch),
        .zero         (zero),
        .flush_ifid   (flush_ifid),
        .flush_idex   (flush_idex),
        .pc_src       (pc_src)
`ifdef BRANCH_HAZARD_STATS_EN
        ,
        .branch_count (branch_count),
        .taken_count  (taken_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: observed no end of test, expected end before 50000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // All three control outputs must agree; expected value replicated.
    task automatic check_out(input string tag, input logic exp);
        check(tag, {29'd0, pc_src, flush_ifid, flush_idex}, {29'd0, {3{exp}}});
    endtask

    task automatic check_cnt(input string tag, input int exp_br, input int exp_tk);
`ifdef BRANCH_HAZARD_STATS_EN
        check({tag, "_branch_count"}, 32'(branch_count), 32'(exp_br));
        check({tag, "_taken_count"}, 32'(taken_count), 32'(exp_tk));
`else
        if (tag.len() < 0) $display("%0d %0d", exp_br, exp_tk);
`endif
    endtask

    // Advance to just after the next rising edge and apply inputs; then let
    // the combinational outputs settle into the middle of the cycle.
    task automatic step(input logic b, input logic z);
        @(posedge clk);
        #1;
        branch = b;
        zero   = z;
        #3;
    endtask

    // Synchronous-looking reset pulse spanning one rising edge, inputs idle.
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst    = 1'b1;
        branch = 1'b0;
        zero   = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        rst    = 1'b1;
        branch = 1'b1;
        zero   = 1'b1;

        // Reset held with a would-be taken branch on the inputs.
        #3;
        check_out("rst_out_a", 1'b0);
        check_cnt("rst_a", 0, 0);
        @(posedge clk);
        @(posedge clk);
        #3;
        check_out("rst_out_b", 1'b0);
        check_cnt("rst_b", 0, 0);

        // Release between edges: first branch is evaluated unmasked at once.
        @(posedge clk);
        #1;
        rst = 1'b0;
        #2;
        check_out("rel_taken", 1'b1);
        step(1'b0, 1'b0);
        check_out("rel_after", 1'b0);
        check_cnt("rel", 1, 1);

        // Truth table 00, 10, 01, 11.
        do_reset();
        branch = 1'b0;
        zero   = 1'b0;
        #2;
        check_out("tt_00", 1'b0);
        step(1'b1, 1'b0);
        check_out("tt_10", 1'b0);
        step(1'b0, 1'b1);
        check_out("tt_01", 1'b0);
        step(1'b1, 1'b1);
        check_out("tt_11", 1'b1);
        step(1'b0, 1'b0);
        check_out("tt_idle", 1'b0);
        check_cnt("tt", 2, 1);

        // Back-to-back taken branches: 1,0,1,0.
        do_reset();
        branch = 1'b1;
        zero   = 1'b1;
        #2;
        check_out("b2b_c0", 1'b1);
        step(1'b1, 1'b1);
        check_out("b2b_c1", 1'b0);
        step(1'b1, 1'b1);
        check_out("b2b_c2", 1'b1);
        step(1'b1, 1'b1);
        check_out("b2b_c3", 1'b0);
        step(1'b0, 1'b0);
        check_cnt("b2b", 2, 2);

        // Masked cycle ignores inputs even with branch=1, zero=0 afterward.
        step(1'b1, 1'b1);
        check_out("mask_take", 1'b1);
        step(1'b1, 1'b0);
        check_out("mask_bubble", 1'b0);
        step(1'b1, 1'b1);
        check_out("mask_retake", 1'b1);

        // Not-taken path for three cycles.
        do_reset();
        branch = 1'b1;
        zero   = 1'b0;
        #2;
        check_out("nt_c0", 1'b0);
        step(1'b1, 1'b0);
        check_out("nt_c1", 1'b0);
        step(1'b1, 1'b0);
        check_out("nt_c2", 1'b0);
        step(1'b0, 1'b0);
        check_cnt("nt", 3, 0);

        // Asynchronous reset pulse inside a taken cycle, both edges between
        // clock edges: outputs drop immediately, no masking after release.
        step(1'b1, 1'b1);
        check_out("mid_taken", 1'b1);
        rst = 1'b1;
        #1;
        check_out("mid_in_rst", 1'b0);
        check_cnt("mid_in_rst", 0, 0);
        rst = 1'b0;
        #1;
        check_out("mid_release", 1'b1);
        step(1'b0, 1'b0);
        check_cnt("mid", 1, 1);

        // Reset held across an edge while a taken branch is presented.
        step(1'b1, 1'b1);
        rst = 1'b1;
        #1;
        check_out("rst_edge_in", 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #2;
        check_out("rst_edge_rel", 1'b1);

        // Counter wrap: 5 taken branches separated by idle cycles, 2-bit counters.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1);
            step(1'b0, 1'b0);
        end
        check_out("wrap_idle", 1'b0);
        check_cnt("wrap", 1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
